// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, GAP} sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first request at or after ptr wins
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down so the candidate nearest ptr is written last and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(ptr) + i) % N);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART transmitter among N_REQ byte requesters
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int LAUNCH_TIMEOUT = 16,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [UART_DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]             grant,
  output logic [N_REQ-1:0]             done,
  output logic                         err_timeout,
  output logic [UART_DATA_W-1:0]       tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic [$clog2(N_REQ)-1:0]     active_id
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int LC_W = $clog2(LAUNCH_TIMEOUT) + 1;
  localparam int GC_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

  sched_state_t state, state_n;
  logic [LC_W-1:0] launch_cnt, launch_cnt_n;
  logic [GC_W-1:0] gap_cnt, gap_cnt_n;
  logic [ID_W-1:0] rr_ptr, rr_ptr_n, next_ptr;
  logic [N_REQ-1:0] grant_n, done_n, arb_gnt;
  logic [ID_W-1:0] arb_idx, active_id_n;
  logic [UART_DATA_W-1:0] tx_data_n, sel_data;
  logic err_n, tx_start_n;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_idx(arb_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == ID_W'(i)) sel_data = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  assign next_ptr = (active_id == ID_LAST) ? '0 : active_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= GAP;
      launch_cnt  <= '0;
      gap_cnt     <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      done        <= '0;
      err_timeout <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      active_id   <= '0;
    end else begin
      state       <= state_n;
      launch_cnt  <= launch_cnt_n;
      gap_cnt     <= gap_cnt_n;
      rr_ptr      <= rr_ptr_n;
      grant       <= grant_n;
      done        <= done_n;
      err_timeout <= err_n;
      tx_data     <= tx_data_n;
      tx_start    <= tx_start_n;
      active_id   <= active_id_n;
    end
  end

  always_comb begin
    state_n      = state;
    launch_cnt_n = launch_cnt;
    gap_cnt_n    = gap_cnt;
    rr_ptr_n     = rr_ptr;
    grant_n      = grant;
    done_n       = '0;
    err_n        = 1'b0;
    tx_data_n    = tx_data;
    tx_start_n   = tx_start;
    active_id_n  = active_id;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_n      = arb_gnt;
          tx_data_n    = sel_data;
          active_id_n  = arb_idx;
          tx_start_n   = 1'b1;
          launch_cnt_n = '0;
          state_n      = LAUNCH;
        end
      end
      LAUNCH: begin
        // Start must drop the moment busy is seen: the transmitter re-samples the level when idle.
        if (tx_busy) begin
          tx_start_n = 1'b0;
          state_n    = SEND;
        end else if (launch_cnt == LC_LAST) begin
          tx_start_n = 1'b0;
          err_n      = 1'b1;
          grant_n    = '0;
          rr_ptr_n   = next_ptr;
          gap_cnt_n  = '0;
          state_n    = GAP;
        end else begin
          launch_cnt_n = launch_cnt + 1'b1;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          done_n    = grant;
          grant_n   = '0;
          rr_ptr_n  = next_ptr;
          gap_cnt_n = '0;
          state_n   = GAP;
        end
      end
      GAP: begin
        tx_start_n = 1'b0;
        if (gap_cnt == GC_LAST) state_n = IDLE;
        else gap_cnt_n = gap_cnt + 1'b1;
      end
      default: state_n = GAP;
    endcase
  end

endmodule
